// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: configurable width, parity and stop bits, with an
// oversampled RX that rejects start-bit glitches and a ready/valid TX handshake.
//
// TX FSM                          RX FSM
// state    | meaning              state    | meaning
// T_IDLE   | ready for a word     R_IDLE   | line idle, waiting for a low
// T_START  | driving start bit    R_START  | confirming start bit at half-bit
// T_DATA   | shifting data LSB 1st R_DATA  | sampling data bits at centres
// T_PARITY | driving parity bit   R_PARITY | sampling parity bit
// T_STOP   | driving stop bit(s)  R_STOP   | sampling stop bit(s)
//                                 R_WAIT   | break/low line, wait for RX=1
module uart_core_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  output logic                 TX,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic                 TX_BUSY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_ACK,
  output logic                 RX_FRAME_ERR,
  output logic                 RX_PARITY_ERR,
  output logic                 RX_OVERRUN
);

  localparam int BIT_DIV    = CLK_FREQ / BAUD;
  localparam int OS_DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;

  localparam logic [15:0] BIT_RELOAD  = 16'(BIT_DIV - 1);
  localparam logic [15:0] OS_RELOAD   = 16'(OS_DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(OVERSAMPLE / 2 - 1);
  localparam logic [15:0] FULL_RELOAD = 16'(OVERSAMPLE - 1);
  localparam logic [3:0]  LAST_BIT    = 4'(DATA_BITS - 1);
  localparam logic        LAST_STOP   = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  tx_state_t             tx_state;
  logic [15:0]           tx_cnt;
  logic [DATA_BITS-1:0]  tx_shift;
  logic                  tx_par;
  logic [3:0]            tx_idx;
  logic                  tx_stop_idx;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state    <= T_IDLE;
      tx_cnt      <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
      TX          <= 1'b1;
      TX_READY    <= 1'b1;
      TX_BUSY     <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (TX_VALID && TX_READY) begin
            tx_shift <= TX_DATA;
            tx_par   <= parity_of(TX_DATA);
            tx_cnt   <= BIT_RELOAD;
            TX       <= 1'b0;
            TX_READY <= 1'b0;
            TX_BUSY  <= 1'b1;
            tx_state <= T_START;
          end
        end
        T_START: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt   <= BIT_RELOAD;
            tx_idx   <= '0;
            TX       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= T_DATA;
          end
        end
        T_DATA: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt <= BIT_RELOAD;
            if (tx_idx == LAST_BIT) begin
              tx_stop_idx <= 1'b0;
              if (PARITY != 0) begin
                TX       <= tx_par;
                tx_state <= T_PARITY;
              end else begin
                TX       <= 1'b1;
                tx_state <= T_STOP;
              end
            end else begin
              tx_idx   <= tx_idx + 4'd1;
              TX       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end
        end
        T_PARITY: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt   <= BIT_RELOAD;
            TX       <= 1'b1;
            tx_state <= T_STOP;
          end
        end
        T_STOP: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else if (tx_stop_idx == LAST_STOP) begin
            TX_READY <= 1'b1;
            TX_BUSY  <= 1'b0;
            TX       <= 1'b1;
            tx_state <= T_IDLE;
          end else begin
            tx_cnt      <= BIT_RELOAD;
            tx_stop_idx <= tx_stop_idx + 1'b1;
          end
        end
        default: begin
          TX       <= 1'b1;
          TX_READY <= 1'b1;
          TX_BUSY  <= 1'b0;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

  logic rx_meta, rx_s;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  rx_state_t             rx_state;
  logic [15:0]           os_cnt;
  logic                  os_tick;
  logic [15:0]           rx_smp;
  logic [DATA_BITS-1:0]  rx_shift;
  logic [3:0]            rx_idx;
  logic                  rx_stop_idx;
  logic                  rx_fe;
  logic                  rx_pe;
  logic                  rx_done;

  assign os_tick = (os_cnt == 16'd0);

  // The oversample divider is held in reload while idle, so the first tick
  // after a falling edge is phase-aligned to that edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_state    <= R_IDLE;
      os_cnt      <= OS_RELOAD;
      rx_smp      <= '0;
      rx_shift    <= '0;
      rx_idx      <= '0;
      rx_stop_idx <= 1'b0;
      rx_fe       <= 1'b0;
      rx_pe       <= 1'b0;
      rx_done     <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (rx_state == R_IDLE || os_cnt == 16'd0)
        os_cnt <= OS_RELOAD;
      else
        os_cnt <= os_cnt - 16'd1;

      case (rx_state)
        R_IDLE: begin
          if (!rx_s) begin
            rx_smp   <= HALF_RELOAD;
            rx_fe    <= 1'b0;
            rx_pe    <= 1'b0;
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (os_tick) begin
            if (rx_smp != 16'd0) begin
              rx_smp <= rx_smp - 16'd1;
            end else if (rx_s) begin
              rx_state <= R_IDLE;
            end else begin
              rx_smp   <= FULL_RELOAD;
              rx_idx   <= '0;
              rx_state <= R_DATA;
            end
          end
        end
        R_DATA: begin
          if (os_tick) begin
            if (rx_smp != 16'd0) begin
              rx_smp <= rx_smp - 16'd1;
            end else begin
              rx_smp   <= FULL_RELOAD;
              rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
              if (rx_idx == LAST_BIT) begin
                rx_stop_idx <= 1'b0;
                rx_state    <= (PARITY != 0) ? R_PARITY : R_STOP;
              end else begin
                rx_idx <= rx_idx + 4'd1;
              end
            end
          end
        end
        R_PARITY: begin
          if (os_tick) begin
            if (rx_smp != 16'd0) begin
              rx_smp <= rx_smp - 16'd1;
            end else begin
              rx_smp   <= FULL_RELOAD;
              rx_pe    <= (rx_s != parity_of(rx_shift));
              rx_state <= R_STOP;
            end
          end
        end
        R_STOP: begin
          if (os_tick) begin
            if (rx_smp != 16'd0) begin
              rx_smp <= rx_smp - 16'd1;
            end else begin
              rx_smp <= FULL_RELOAD;
              if (!rx_s) rx_fe <= 1'b1;
              if (rx_stop_idx == LAST_STOP) begin
                rx_done  <= 1'b1;
                rx_state <= rx_s ? R_IDLE : R_WAIT;
              end else begin
                rx_stop_idx <= rx_stop_idx + 1'b1;
              end
            end
          end
        end
        R_WAIT: begin
          if (rx_s) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // An ack landing on the delivery cycle frees the slot, so the new word wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RX_DATA       <= '0;
      RX_VALID      <= 1'b0;
      RX_FRAME_ERR  <= 1'b0;
      RX_PARITY_ERR <= 1'b0;
      RX_OVERRUN    <= 1'b0;
    end else if (rx_done && (!RX_VALID || RX_ACK)) begin
      RX_DATA       <= rx_shift;
      RX_VALID      <= 1'b1;
      RX_FRAME_ERR  <= rx_fe;
      RX_PARITY_ERR <= rx_pe;
      RX_OVERRUN    <= 1'b0;
    end else if (rx_done) begin
      RX_OVERRUN <= 1'b1;
    end else if (RX_ACK && RX_VALID) begin
      RX_VALID      <= 1'b0;
      RX_FRAME_ERR  <= 1'b0;
      RX_PARITY_ERR <= 1'b0;
      RX_OVERRUN    <= 1'b0;
    end
  end

endmodule
